// File: rtl/vga_text_console.sv
// Character-stream front end for the VGA text frame buffer: hardware cursor, printable writes,
// control codes, line/screen clears. Define VGA_TEXT_CONSOLE_TAB_EN to make 0x09 pad to 8 columns.
module vga_text_console #(
  parameter int          COLS       = 80,
  parameter int          ROWS       = 30,
  parameter logic [7:0]  CLEAR_ATTR = 8'h07
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic [7:0]  attr,
  output logic        fb_en,
  output logic [3:0]  fb_we,
  output logic [10:0] fb_addr,
  output logic [31:0] fb_wdata,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy
);

  // state        | meaning
  // INIT         | first cycle after reset, outputs idle, then full clear
  // CLEAR_SCREEN | one blank word per cycle over the whole buffer
  // IDLE         | accepting a byte; control codes act here
  // WRITE        | one cell write at the cursor, then advance
  // CLEAR_LINE   | blank the row the cursor wrapped onto
  // TAB          | blank cells up to the next multiple of 8 (optional)
  typedef enum logic [2:0] {
    ST_INIT, ST_CLEAR_SCREEN, ST_IDLE, ST_WRITE, ST_CLEAR_LINE, ST_TAB
  } state_t;

  localparam int SCREEN_WORDS = ROWS * COLS / 2;
  localparam int LINE_WORDS   = COLS / 2;
  localparam logic [31:0] BLANK_WORD = {2{CLEAR_ATTR, 8'h20}};

  state_t      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [6:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic [7:0]  ch_q, ch_d;
  logic [7:0]  at_q, at_d;

  logic [11:0] cell_idx;
  logic [10:0] line_base;
  logic [6:0]  adv_col;
  logic [4:0]  adv_row, nl_row;
  logic        adv_wrap, nl_wrap;
  logic [15:0] cell_word;

  assign cell_idx  = 12'(row_q) * 12'(COLS) + 12'(col_q);
  assign line_base = 11'(row_q) * 11'(LINE_WORDS);

  // Newline and auto-advance share the row-increment/wrap rule.
  always_comb begin
    nl_wrap = 1'b0;
    nl_row  = row_q + 5'd1;
    if (row_q == 5'(ROWS - 1)) begin
      nl_row  = 5'd0;
      nl_wrap = 1'b1;
    end
    adv_col  = col_q + 7'd1;
    adv_row  = row_q;
    adv_wrap = 1'b0;
    if (col_q == 7'(COLS - 1)) begin
      adv_col  = 7'd0;
      adv_row  = nl_row;
      adv_wrap = nl_wrap;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      ch_q    <= '0;
      at_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      ch_q    <= ch_d;
      at_q    <= at_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    ch_d    = ch_q;
    at_d    = at_q;
    case (state_q)
      ST_INIT: begin
        state_d = ST_CLEAR_SCREEN;
        cnt_d   = '0;
      end
      ST_CLEAR_SCREEN: begin
        if (cnt_q == 11'(SCREEN_WORDS - 1)) begin
          state_d = ST_IDLE;
          col_d   = '0;
          row_d   = '0;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      ST_IDLE: begin
        if (in_valid) begin
          cnt_d = '0;
          if (in_data >= 8'h20 && in_data <= 8'h7E) begin
            state_d = ST_WRITE;
            ch_d    = in_data;
            at_d    = attr;
          end else begin
            case (in_data)
              8'h0A: begin
                col_d = '0;
                row_d = nl_row;
                if (nl_wrap) state_d = ST_CLEAR_LINE;
              end
              8'h0D: col_d = '0;
              8'h08: if (col_q != 7'd0) col_d = col_q - 7'd1;
              8'h0C: state_d = ST_CLEAR_SCREEN;
`ifdef VGA_TEXT_CONSOLE_TAB_EN
              8'h09: begin
                state_d = ST_TAB;
                at_d    = attr;
              end
`endif
              default: ;
            endcase
          end
        end
      end
      ST_WRITE: begin
        col_d   = adv_col;
        row_d   = adv_row;
        cnt_d   = '0;
        state_d = adv_wrap ? ST_CLEAR_LINE : ST_IDLE;
      end
      ST_CLEAR_LINE: begin
        if (cnt_q == 11'(LINE_WORDS - 1)) state_d = ST_IDLE;
        else cnt_d = cnt_q + 11'd1;
      end
`ifdef VGA_TEXT_CONSOLE_TAB_EN
      ST_TAB: begin
        col_d = adv_col;
        row_d = adv_row;
        cnt_d = '0;
        // A wrap lands on column 0, which is always a tab stop.
        if (adv_wrap) state_d = ST_CLEAR_LINE;
        else if (adv_col[2:0] == 3'd0) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_INIT;
    endcase
  end

  assign cell_word = (state_q == ST_TAB) ? {at_q, 8'h20} : {at_q, ch_q};

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b1;
    fb_en    = 1'b0;
    fb_we    = 4'h0;
    fb_addr  = '0;
    fb_wdata = '0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      ST_CLEAR_SCREEN: begin
        fb_en    = 1'b1;
        fb_we    = 4'hF;
        fb_addr  = cnt_q;
        fb_wdata = BLANK_WORD;
      end
      ST_CLEAR_LINE: begin
        fb_en    = 1'b1;
        fb_we    = 4'hF;
        fb_addr  = line_base + cnt_q;
        fb_wdata = BLANK_WORD;
      end
      ST_WRITE, ST_TAB: begin
        fb_en    = 1'b1;
        fb_we    = cell_idx[0] ? 4'b1100 : 4'b0011;
        fb_addr  = cell_idx[11:1];
        fb_wdata = {cell_word, cell_word};
      end
      default: ;
    endcase
  end

  assign cursor_col = col_q;
  assign cursor_row = row_q;

endmodule

// File: tb/tb_vga_text_console.sv
// Directed bench for vga_text_console with hand-computed frame-buffer writes and cursor positions.
module tb_vga_text_console;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [7:0]  attr;
  logic        fb_en;
  logic [3:0]  fb_we;
  logic [10:0] fb_addr;
  logic [31:0] fb_wdata;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int we_viol = 0;
  logic [10:0] log_addr[$];
  logic [3:0]  log_we[$];
  logic [31:0] log_wdata[$];

  vga_text_console dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .attr(attr), .fb_en(fb_en), .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
  );

  always #5 clk = ~clk;

  // Record one entry per clock cycle in which the buffer is enabled.
  always begin
    @(posedge clk);
    #1;
    if (fb_en) begin
      log_addr.push_back(fb_addr);
      log_we.push_back(fb_we);
      log_wdata.push_back(fb_wdata);
    end else if (fb_we != 4'h0) begin
      we_viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_we.delete();
    log_wdata.delete();
  endtask

  task automatic wait_ready(input int limit, input string tag);
    int n = 0;
    while (!in_ready && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] a);
    wait_ready(2000, "ready_timeout");
    in_valid = 1'b1;
    in_data  = d;
    attr     = a;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_cursor(input string tag, input int col, input int row);
    wait_ready(2000, "ready_timeout");
    check({tag, "_col"}, 32'(cursor_col), 32'(col));
    check({tag, "_row"}, 32'(cursor_row), 32'(row));
  endtask

  // Blank words from log index 'first' must cover addresses base..base+count-1 in order.
  task automatic check_blank_run(input string tag, input int first, input int base, input int count);
    int bad = 0;
    for (int i = 0; i < count; i++) begin
      if (first + i >= log_addr.size()) bad++;
      else if (log_addr[first+i] != 11'(base + i) || log_we[first+i] != 4'hF ||
               log_wdata[first+i] != 32'h0720_0720) bad++;
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    int n;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    attr     = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, in_ready}, 32'd0);
    check("rst_fb_en", {31'd0, fb_en}, 32'd0);
    check("rst_fb_we", {28'd0, fb_we}, 32'd0);
    check("rst_addr", {21'd0, fb_addr}, 32'd0);
    check("rst_wdata", fb_wdata, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_cursor", {20'd0, cursor_col, cursor_row}, 32'd0);
    clear_log();
    reset = 1'b0;

    // Power-up clear
    wait_ready(1400, "init_clear_timeout");
    check("init_clear_count", 32'(log_addr.size()), 32'd1200);
    check_blank_run("init_clear_seq", 0, 0, 1200);
    check_cursor("init_cursor", 0, 0);

    // Two printable characters sharing word 0
    clear_log();
    send(8'h41, 8'h1E);
    send(8'h42, 8'h07);
    check_cursor("ab_cursor", 2, 0);
    check("ab_count", 32'(log_addr.size()), 32'd2);
    if (log_addr.size() >= 2) begin
      check("a_addr", {21'd0, log_addr[0]}, 32'd0);
      check("a_we", {28'd0, log_we[0]}, 32'h3);
      check("a_wdata", log_wdata[0], 32'h1E41_1E41);
      check("b_addr", {21'd0, log_addr[1]}, 32'd0);
      check("b_we", {28'd0, log_we[1]}, 32'hC);
      check("b_wdata", log_wdata[1], 32'h0742_0742);
    end

    // Control codes from (5,3)
    repeat (3) send(8'h0A, 8'h07);
    repeat (5) send(8'h78, 8'h07);
    check_cursor("pos53", 5, 3);
    clear_log();
    send(8'h0D, 8'h07);
    check_cursor("cr", 0, 3);
    send(8'h0A, 8'h07);
    check_cursor("lf", 0, 4);
    send(8'h08, 8'h07);
    check_cursor("bs_col0", 0, 4);
    send(8'h7F, 8'h07);
    send(8'hC3, 8'h07);
    check_cursor("ignored", 0, 4);
    check("ctrl_no_writes", 32'(log_addr.size()), 32'd0);
    send(8'h71, 8'h07);
    check_cursor("q_cursor", 1, 4);
    check("q_count", 32'(log_addr.size()), 32'd1);
    if (log_addr.size() >= 1) check("q_addr", {21'd0, log_addr[0]}, 32'd160);
    send(8'h08, 8'h07);
    check_cursor("bs", 0, 4);

    // Last cell of the screen, wrap to row 0 with line clear
    repeat (25) send(8'h0A, 8'h07);
    repeat (79) send(8'h61, 8'h07);
    check_cursor("pos79_29", 79, 29);
    wait_ready(50, "ready_timeout");
    clear_log();
    in_valid = 1'b1;
    in_data  = 8'h5A;
    attr     = 8'h07;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(posedge clk);
      #1;
    end
    check("wrap_busy_cycles", 32'(n), 32'd41);
    check_cursor("wrap_cursor", 0, 0);
    check("wrap_count", 32'(log_addr.size()), 32'd41);
    if (log_addr.size() >= 1) begin
      check("z_addr", {21'd0, log_addr[0]}, 32'd1199);
      check("z_we", {28'd0, log_we[0]}, 32'hC);
      check("z_wdata", log_wdata[0], 32'h075A_075A);
    end
    check_blank_run("wrap_clear_seq", 1, 0, 40);

    // Form feed interrupted by reset at word 600
    send(8'h61, 8'h07);
    check_cursor("ff_pre", 1, 0);
    send(8'h0C, 8'h07);
    n = 0;
    while (!(fb_en && fb_addr == 11'd600) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("ff_reached_600", {31'd0, fb_en}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_fb_en", {31'd0, fb_en}, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd1);
    check("mid_rst_cursor", {20'd0, cursor_col, cursor_row}, 32'd0);
    @(negedge clk);
    check("mid_rst_fb_en2", {31'd0, fb_en}, 32'd0);
    @(negedge clk);
    clear_log();
    reset = 1'b0;
    wait_ready(1400, "reclear_timeout");
    check("reclear_count", 32'(log_addr.size()), 32'd1200);
    check_blank_run("reclear_seq", 0, 0, 1200);

    // Tab from (3,0)
    send(8'h61, 8'h07);
    send(8'h62, 8'h07);
    send(8'h63, 8'h07);
    check_cursor("tab_pre", 3, 0);
    clear_log();
    send(8'h09, 8'h5A);
`ifdef VGA_TEXT_CONSOLE_TAB_EN
    check_cursor("tab_cursor", 8, 0);
    check("tab_count", 32'(log_addr.size()), 32'd5);
    if (log_addr.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        check($sformatf("tab_addr%0d", i), {21'd0, log_addr[i]}, 32'((3 + i) / 2));
        check($sformatf("tab_we%0d", i), {28'd0, log_we[i]}, ((3 + i) % 2 == 1) ? 32'hC : 32'h3);
        check($sformatf("tab_wdata%0d", i), log_wdata[i], 32'h5A20_5A20);
      end
    end
`else
    check_cursor("tab_cursor", 3, 0);
    check("tab_count", 32'(log_addr.size()), 32'd0);
`endif

    check("we_without_en", 32'(we_viol), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
